// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: synchronises raw pad inputs into clk, rejects
// short pulses and produces filtered levels, edge strobes and sticky glitch flags.
module sync_filter_bank #(
    parameter int                 WIDTH       = 2,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             bypass,
    input  logic [WIDTH-1:0] glitch_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [CW-1:0]    cnt_r  [WIDTH];
    logic [CW-1:0]    cnt_nx [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] glitch_set;
    logic [WIDTH-1:0] glitch_nx;

    assign s = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= RESET_VALUE;
            end
        end else begin
            sync_r[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // The counter tracks how long s has disagreed with q; reaching FILTER_LEN-1
    // on a further disagreeing edge accepts the new level.
    always_comb begin
        q_nx       = q;
        glitch_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nx[i] = '0;
            if (bypass) begin
                q_nx[i] = s[i];
            end else if (s[i] == q[i]) begin
                glitch_set[i] = (cnt_r[i] != '0);
            end else if (cnt_r[i] == CNT_LAST) begin
                q_nx[i] = s[i];
            end else begin
                cnt_nx[i] = cnt_r[i] + 1'b1;
            end
        end
        glitch_nx = (glitch & ~glitch_clr) | glitch_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RESET_VALUE;
            rise   <= '0;
            fall   <= '0;
            glitch <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            q      <= q_nx;
            rise   <= q_nx & ~q;
            fall   <= ~q_nx & q;
            glitch <= glitch_nx;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: three instances (FILTER_LEN 3, 1, 255) share inputs and
// are compared each cycle against a run-length reference model plus directed checks.
module tb_sync_filter_bank;

    localparam int           W   = 2;
    localparam int           SS  = 2;
    localparam int           NI  = 3;
    localparam logic [W-1:0] RV  = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d = 2'b00;
    logic         bypass = 1'b0;
    logic [W-1:0] glitch_clr = 2'b00;

    logic [W-1:0] q3, rise3, fall3, glitch3;
    logic [W-1:0] q1, rise1, fall1, glitch1;
    logic [W-1:0] q255, rise255, fall255, glitch255;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_filter_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(3), .RESET_VALUE(RV)) u_f3 (
        .clk(clk), .rst_n(rst_n), .d(d), .bypass(bypass), .glitch_clr(glitch_clr),
        .q(q3), .rise(rise3), .fall(fall3), .glitch(glitch3));

    sync_filter_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(1), .RESET_VALUE(RV)) u_f1 (
        .clk(clk), .rst_n(rst_n), .d(d), .bypass(bypass), .glitch_clr(glitch_clr),
        .q(q1), .rise(rise1), .fall(fall1), .glitch(glitch1));

    sync_filter_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(255), .RESET_VALUE(RV)) u_f255 (
        .clk(clk), .rst_n(rst_n), .d(d), .bypass(bypass), .glitch_clr(glitch_clr),
        .q(q255), .rise(rise255), .fall(fall255), .glitch(glitch255));

    // Reference model: s is d delayed by SS edges; run counts consecutive
    // disagreeing edges, a new level is taken once the run reaches FILTER_LEN.
    logic [W-1:0] m_q [NI];
    logic [W-1:0] m_rise [NI];
    logic [W-1:0] m_fall [NI];
    logic [W-1:0] m_glitch [NI];
    int           m_run [NI][W];
    logic [W-1:0] s_line [$];

    function automatic int fl_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [W-1:0] s_cur;
        logic         old_b, new_b, set_b;
        if (!rst_n) begin
            s_line.delete();
            for (int j = 0; j < SS; j++) s_line.push_back(RV);
            for (int k = 0; k < NI; k++) begin
                m_q[k] = RV; m_rise[k] = '0; m_fall[k] = '0; m_glitch[k] = '0;
                for (int i = 0; i < W; i++) m_run[k][i] = 0;
            end
        end else begin
            s_cur = s_line.pop_front();
            s_line.push_back(d);
            for (int k = 0; k < NI; k++) begin
                for (int i = 0; i < W; i++) begin
                    old_b = m_q[k][i];
                    new_b = old_b;
                    set_b = 1'b0;
                    if (bypass) begin
                        new_b = s_cur[i];
                        m_run[k][i] = 0;
                    end else if (s_cur[i] != old_b) begin
                        m_run[k][i] = m_run[k][i] + 1;
                        if (m_run[k][i] >= fl_of(k)) begin
                            new_b = s_cur[i];
                            m_run[k][i] = 0;
                        end
                    end else begin
                        set_b = (m_run[k][i] > 0);
                        m_run[k][i] = 0;
                    end
                    m_rise[k][i]   = !old_b && new_b;
                    m_fall[k][i]   = old_b && !new_b;
                    m_q[k][i]      = new_b;
                    m_glitch[k][i] = (m_glitch[k][i] && !glitch_clr[i]) || set_b;
                end
            end
        end
    end

    logic [4*W*NI-1:0] obs_vec, exp_vec;
    assign obs_vec = {q3, rise3, fall3, glitch3, q1, rise1, fall1, glitch1,
                      q255, rise255, fall255, glitch255};
    assign exp_vec = {m_q[0], m_rise[0], m_fall[0], m_glitch[0],
                      m_q[1], m_rise[1], m_fall[1], m_glitch[1],
                      m_q[2], m_rise[2], m_fall[2], m_glitch[2]};

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; d = RV; bypass = 1'b0; glitch_clr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; d = 2'b00; bypass = 1'b0; glitch_clr = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({q3, q1, q255} !== 6'h3f) begin
            n_fail++; $display("FAIL reset_q: got %h want 3f", {q3, q1, q255});
        end
        n_cmp++;
        if ({rise3, fall3, glitch3, rise1, fall1, glitch1, rise255, fall255, glitch255} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got %h want 0",
                {rise3, fall3, glitch3, rise1, fall1, glitch1, rise255, fall255, glitch255});
        end
        d = 2'b11; rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_cmp++;
            if ({rise3, fall3, rise1, fall1, rise255, fall255} !== '0) begin
                n_fail++; $display("FAIL reset_release_strobe e%0d: got %h want 0", e,
                    {rise3, fall3, rise1, fall1, rise255, fall255});
            end
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL reset_release_model e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_accept_edge();
        int lat [NI];
        for (int k = 0; k < NI; k++) lat[k] = -1;
        do_reset();
        d = 2'b10;
        for (int e = 1; e <= 262; e++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL accept_model e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
            if (lat[0] < 0 && q3[0] == 1'b0) lat[0] = e;
            if (lat[1] < 0 && q1[0] == 1'b0) lat[1] = e;
            if (lat[2] < 0 && q255[0] == 1'b0) lat[2] = e;
            if (e <= 7) begin
                n_cmp++;
                if ({q3[1], fall3[0]} !== {1'b1, (e == 5)}) begin
                    n_fail++; $display("FAIL accept_fall_pulse e%0d: got %b want %b", e,
                        {q3[1], fall3[0]}, {1'b1, (e == 5)});
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (lat[k] != SS + fl_of(k)) begin
                n_fail++; $display("FAIL latency_fl%0d: got %0d want %0d", fl_of(k), lat[k], SS + fl_of(k));
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 1; e <= 18; e++) begin
            d          = (e == 1 || e == 2 || e == 11 || e == 12) ? 2'b01 : 2'b11;
            glitch_clr = (e == 8 || e == 15) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL glitch_model e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
            if (e == 5 || e == 7 || e == 15 || e == 16) begin
                n_cmp++;
                if ({q3[1], glitch3[1], glitch1[1]} !== 3'b110) begin
                    n_fail++; $display("FAIL glitch_set e%0d: got %b want 110", e,
                        {q3[1], glitch3[1], glitch1[1]});
                end
            end
            if (e == 8) begin
                n_cmp++;
                if (glitch3[1] !== 1'b0) begin
                    n_fail++; $display("FAIL glitch_clear: got %b want 0", glitch3[1]);
                end
            end
        end
        glitch_clr = '0;
    endtask

    task automatic test_bypass();
        do_reset();
        bypass = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            d = (e == 1) ? 2'b10 : 2'b11;
            @(negedge clk);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL bypass_model e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
            n_cmp++;
            if ({q3[0], fall3[0], rise3[0], glitch3} !== {(e != 3), (e == 3), (e == 4), 2'b00}) begin
                n_fail++; $display("FAIL bypass_pulse e%0d: got %b want %b", e,
                    {q3[0], fall3[0], rise3[0], glitch3}, {(e != 3), (e == 3), (e == 4), 2'b00});
            end
        end
        bypass = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d = 2'b10;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL reset_mid_pre e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({q3, q1, q255, rise1, fall1, rise3, fall3} !== {6'h3f, 8'h00}) begin
            n_fail++; $display("FAIL reset_mid_async: got %h want %h",
                {q3, q1, q255, rise1, fall1, rise3, fall3}, {6'h3f, 8'h00});
        end
        @(negedge clk);
        d = 2'b11; rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            n_cmp++;
            if ({rise3, fall3, rise1, fall1, rise255, fall255} !== '0 || obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL reset_mid_release e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_long_pulse();
        do_reset();
        for (int e = 1; e <= 262; e++) begin
            d = (e <= 254) ? 2'b10 : 2'b11;
            @(negedge clk);
            n_cmp++;
            if (q255[0] !== 1'b1 || obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL long_pulse e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (glitch255[0] !== 1'b1) begin
            n_fail++; $display("FAIL long_pulse_glitch: got %b want 1", glitch255[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 600; e++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 2) == 0) d[i] = ~d[i];
            end
            if ($urandom_range(0, 39) == 0) bypass = ~bypass;
            glitch_clr = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3)) : '0;
            @(negedge clk);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL random e%0d: got %h want %h", e, obs_vec, exp_vec);
            end
        end
        bypass = 1'b0; glitch_clr = '0;
    endtask

    initial begin
        test_reset();
        test_accept_edge();
        test_glitch();
        test_bypass();
        test_reset_mid();
        test_long_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
